// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD engine.
// The iteration limit is enabled by defining GCD_ITER_LIMIT_EN.
package gcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } gcd_state_t;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_MAX_ITER = 1000;

  // Bit positions inside the result status register
  localparam int STAT_ZERO    = 0;
  localparam int STAT_TIMEOUT = 1;
  localparam int STAT_W       = 2;

endpackage

// File: rtl/gcd_step.sv
// One subtractive Euclid step: compares A and B and forms the next pair.
// Purely combinational; the engine decides whether the step is taken.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next
);

  always_comb begin
    eq     = (a == b);
    gt     = (a > b);
    a_next = a;
    b_next = b;
    // The larger operand absorbs the subtraction, so no underflow is possible
    if (gt) begin
      a_next = a - b;
    end else if (!eq) begin
      b_next = b - a;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Subtractive GCD unit with valid/ready operand and result channels.
// Optional iteration limit: define GCD_ITER_LIMIT_EN to honour MAX_ITER.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_ITER = DEF_MAX_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [CNT_W-1:0] out_iters,
  output logic             out_zero,
  output logic             out_timeout,
  output logic             busy
);

`ifdef GCD_ITER_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

  gcd_state_t          state_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STAT_W-1:0]   status_q;

  logic                step_eq;
  logic                step_gt;
  logic [WIDTH-1:0]    a_nxt;
  logic [WIDTH-1:0]    b_nxt;
  logic                limit_hit;
  logic                accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  gcd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a      (a_q),
    .b      (b_q),
    .eq     (step_eq),
    .gt     (step_gt),
    .a_next (a_nxt),
    .b_next (b_nxt)
  );

  assign accept    = in_valid && in_ready;
  assign limit_hit = LIMIT_EN && (cnt_q == ITER_LIMIT);

  // The counter doubles as the reported iteration count; it only clears on accept
  assign out_iters   = cnt_q;
  assign out_zero    = status_q[STAT_ZERO];
  assign out_timeout = status_q[STAT_TIMEOUT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      out_gcd   <= '0;
      status_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            a_q      <= in_a;
            b_q      <= in_b;
            cnt_q    <= '0;
            status_q <= '0;
            in_ready <= 1'b0;
            if ((in_a == '0) || (in_b == '0)) begin
              state_q             <= ST_DONE;
              out_valid           <= 1'b1;
              out_gcd             <= in_a | in_b;
              status_q[STAT_ZERO] <= 1'b1;
            end else begin
              state_q <= ST_COMPUTE;
              busy    <= 1'b1;
            end
          end
        end

        ST_COMPUTE: begin
          // Equality wins over the limit so a result landing on MAX_ITER is kept
          if (step_eq) begin
            state_q   <= ST_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out_gcd   <= a_q;
          end else if (limit_hit) begin
            state_q                <= ST_DONE;
            busy                   <= 1'b0;
            out_valid              <= 1'b1;
            out_gcd                <= '0;
            status_q[STAT_TIMEOUT] <= 1'b1;
          end else begin
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed cases plus randomized pairs
// compared against a Euclid (divide/remainder) reference model.
module tb_gcd_engine;

  localparam int WIDTH    = 16;
  localparam int CNT_W    = 16;
  localparam int MAX_ITER = 1000;
  localparam int WAIT_MAX = 70000;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic [CNT_W-1:0] out_iters;
  logic             out_zero;
  logic             out_timeout;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  gcd_engine #(
    .WIDTH    (WIDTH),
    .CNT_W    (CNT_W),
    .MAX_ITER (MAX_ITER)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_gcd     (out_gcd),
    .out_iters   (out_iters),
    .out_zero    (out_zero),
    .out_timeout (out_timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: subtractive step count from Euclid quotients.
  // A stage a = q*b + r costs q subtractions, or q-1 when it ends in equality.
  task automatic ref_model(input int unsigned a, input int unsigned b,
                           output int unsigned g, output int unsigned it,
                           output bit z, output bit to);
    int unsigned x, y, t, q, r;
    it = 0; z = 0; to = 0; g = 0;
    if (a == 0 || b == 0) begin
      g = a | b;
      z = 1;
      return;
    end
    x = a; y = b;
    forever begin
      if (x < y) begin t = x; x = y; y = t; end
      q = x / y;
      r = x % y;
      if (r == 0) begin
        it += q - 1;
        g = y;
        break;
      end
      it += q;
      x = y;
      y = r;
    end
`ifdef GCD_ITER_LIMIT_EN
    if (it > MAX_ITER) begin
      g  = 0;
      it = MAX_ITER;
      to = 1;
    end
`endif
  endtask

  // Offers one pair, then waits for out_valid. lat = edges after the accept
  // edge at which out_valid became visible; bcyc = sampled cycles with busy.
  task automatic do_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int lat, output int bcyc);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin step(); guard++; end
    check_eq("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    step();
    in_valid = 1'b0;
    in_a = WIDTH'($urandom);
    in_b = WIDTH'($urandom);
    lat = 0;
    bcyc = 0;
    while (!out_valid && lat < WAIT_MAX) begin
      if (busy) bcyc++;
      step();
      lat++;
    end
    if (!out_valid) check_eq("out_valid_wait", out_valid, 1);
  endtask

  task automatic check_result(input string tag, input int unsigned a, input int unsigned b,
                              input int lat, input bit check_lat);
    int unsigned g, it;
    bit z, to;
    ref_model(a, b, g, it, z, to);
    check_eq({tag, "_gcd"}, out_gcd, g);
    check_eq({tag, "_iters"}, out_iters, it);
    check_eq({tag, "_zero"}, out_zero, z);
    check_eq({tag, "_timeout"}, out_timeout, to);
    if (check_lat) check_eq({tag, "_lat"}, lat, z ? 0 : it + 1);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    check_eq({tag, "_valid_drop"}, out_valid, 0);
    check_eq({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int lat, bcyc;
    int unsigned x, y, k, ra, rb;
    logic [WIDTH-1:0] held_gcd;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    #12;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_gcd", out_gcd, 0);
    check_eq("rst_iters", out_iters, 0);
    check_eq("rst_zero", out_zero, 0);
    check_eq("rst_timeout", out_timeout, 0);
    rst_n = 1'b1;
    step();
    check_eq("idle_in_ready", in_ready, 1);

    // Basic nonzero pair with latency and busy duration
    do_pair(16'd48, 16'd18, lat, bcyc);
    check_eq("p48_gcd", out_gcd, 6);
    check_eq("p48_iters", out_iters, 4);
    check_eq("p48_zero", out_zero, 0);
    check_eq("p48_lat", lat, 5);
    check_eq("p48_busy", bcyc, 5);
    handshake("p48");

    // Zero operands and equal operands
    do_pair(16'd0, 16'd7, lat, bcyc);
    check_result("z07", 0, 7, lat, 1);
    handshake("z07");
    do_pair(16'd0, 16'd0, lat, bcyc);
    check_result("z00", 0, 0, lat, 1);
    handshake("z00");
    do_pair(16'hFFFF, 16'hFFFF, lat, bcyc);
    check_result("eqmax", 16'hFFFF, 16'hFFFF, lat, 1);
    check_eq("eqmax_lat_abs", lat, 1);
    handshake("eqmax");

    // Backpressure: result held, no acceptance while in_valid stays high
    out_ready = 1'b0;
    do_pair(16'd21, 16'd14, lat, bcyc);
    check_result("bp", 21, 14, lat, 1);
    held_gcd = out_gcd;
    in_valid = 1'b1;
    in_a = 16'd100;
    in_b = 16'd75;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_hold_valid", out_valid, 1);
      check_eq("bp_hold_gcd", out_gcd, held_gcd);
      check_eq("bp_hold_iters", out_iters, 2);
      check_eq("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    handshake("bp");
    do_pair(16'd9, 16'd6, lat, bcyc);
    check_result("bp_next", 9, 6, lat, 1);
    handshake("bp_next");

    // Reset in the middle of a long computation
    in_valid = 1'b1;
    in_a = 16'd65535;
    in_b = 16'd1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    check_eq("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_gcd", out_gcd, 0);
    check_eq("mid_rst_iters", out_iters, 0);
    check_eq("mid_rst_zero", out_zero, 0);
    check_eq("mid_rst_timeout", out_timeout, 0);
    step();
    rst_n = 1'b1;
    do_pair(16'd12, 16'd8, lat, bcyc);
    check_eq("post_rst_gcd", out_gcd, 4);
    check_eq("post_rst_iters", out_iters, 2);
    handshake("post_rst");

    // Worst case: limited with the macro, full run without it
    do_pair(16'd65535, 16'd1, lat, bcyc);
`ifdef GCD_ITER_LIMIT_EN
    check_eq("worst_timeout", out_timeout, 1);
    check_eq("worst_gcd", out_gcd, 0);
    check_eq("worst_iters", out_iters, MAX_ITER);
`else
    check_eq("worst_timeout", out_timeout, 0);
    check_eq("worst_gcd", out_gcd, 1);
    check_eq("worst_iters", out_iters, 65534);
`endif
    handshake("worst");

    // Random back-to-back pairs with a common factor to spread the gcd values
    for (int n = 0; n < 200; n++) begin
      x = $urandom_range(255, 1);
      y = $urandom_range(255, 1);
      k = $urandom_range(255, 1);
      ra = k * x;
      rb = k * y;
      do_pair(WIDTH'(ra), WIDTH'(rb), lat, bcyc);
      check_result("rnd", ra, rb, lat, 1);
      out_ready = 1'b1;
      step();
      if (out_valid) check_eq("rnd_valid_drop", out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
